// File: rtl/cic_integrator_cascade_if.sv
// Sample stream bundle for the CIC integrator cascade: input samples in, integrated samples out.
interface cic_integrator_cascade_if #(
  parameter int IN_WIDTH  = 12,
  parameter int ACC_WIDTH = 32,
  parameter int CH_WIDTH  = 4
);
  logic                        x_valid;
  logic [CH_WIDTH-1:0]         x_ch;
  logic signed [IN_WIDTH-1:0]  x;
  logic                        y_valid;
  logic [CH_WIDTH-1:0]         y_ch;
  logic signed [ACC_WIDTH-1:0] y;

  modport master (output x_valid, x_ch, x, input y_valid, y_ch, y);
  modport slave  (input x_valid, x_ch, x, output y_valid, y_ch, y);
endinterface

// File: rtl/cic_integrator_cascade.sv
// Time-multiplexed N-stage CIC integrator cascade, one sample per clock, wrap-around arithmetic.
// Optional per-channel accumulator clear: define CIC_INTEGRATOR_CASCADE_CLEAR_EN.
module cic_integrator_cascade #(
  parameter int IN_WIDTH  = 12,
  parameter int ACC_WIDTH = 32,
  parameter int STAGES    = 4,
  parameter int CHANNELS  = 1,
  parameter int CH_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
  input  logic                clr,
  input  logic [CH_WIDTH-1:0] clr_ch,
`endif
  cic_integrator_cascade_if.slave stream
);

  localparam logic [CH_WIDTH:0] CH_LIMIT = (CH_WIDTH+1)'(CHANNELS);

  function automatic logic signed [ACC_WIDTH-1:0] sign_extend(input logic signed [IN_WIDTH-1:0] s);
    return ACC_WIDTH'(s);
  endfunction

  // Modulo 2^ACC_WIDTH; the comb section downstream depends on this wrap.
  function automatic logic signed [ACC_WIDTH-1:0] wrap_add(input logic signed [ACC_WIDTH-1:0] a,
                                                           input logic signed [ACC_WIDTH-1:0] b);
    return a + b;
  endfunction

  logic signed [ACC_WIDTH-1:0] acc    [STAGES][CHANNELS];
  logic signed [ACC_WIDTH-1:0] d_p    [STAGES];
  logic [CH_WIDTH-1:0]         ch_p   [STAGES];
  logic                        vld_p  [STAGES];

  logic signed [ACC_WIDTH-1:0] d_in   [STAGES];
  logic [CH_WIDTH-1:0]         ch_in  [STAGES];
  logic                        vld_in [STAGES];
  logic signed [ACC_WIDTH-1:0] acc_rd [STAGES];
  logic signed [ACC_WIDTH-1:0] sum    [STAGES];
  logic                        clr_hit[STAGES];
  logic                        clr_en;
  logic [CH_WIDTH-1:0]         clr_sel;

`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
  assign clr_en  = clr;
  assign clr_sel = clr_ch;
`else
  assign clr_en  = 1'b0;
  assign clr_sel = '0;
`endif

  always_comb begin
    d_in[0]   = sign_extend(stream.x);
    ch_in[0]  = stream.x_ch;
    vld_in[0] = stream.x_valid && ({1'b0, stream.x_ch} < CH_LIMIT);
    for (int k = 1; k < STAGES; k++) begin
      d_in[k]   = d_p[k-1];
      ch_in[k]  = ch_p[k-1];
      vld_in[k] = vld_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      acc_rd[k] = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_in[k] == CH_WIDTH'(c)) acc_rd[k] = acc[k][c];
      end
      sum[k]     = wrap_add(acc_rd[k], d_in[k]);
      clr_hit[k] = vld_in[k] && clr_en && (ch_in[k] == clr_sel);
    end
  end

  // Stage k registers: accumulator read-modify-write and the d/ch/vld pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        d_p[k]   <= '0;
        ch_p[k]  <= '0;
        for (int c = 0; c < CHANNELS; c++) acc[k][c] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= vld_in[k];
        if (vld_in[k]) begin
          ch_p[k] <= ch_in[k];
          if (clr_hit[k]) d_p[k] <= (k == 0) ? '0 : d_in[k];
          else            d_p[k] <= sum[k];
        end
        for (int c = 0; c < CHANNELS; c++) begin
          if (clr_en && clr_sel == CH_WIDTH'(c))
            acc[k][c] <= '0;
          else if (vld_in[k] && ch_in[k] == CH_WIDTH'(c))
            acc[k][c] <= sum[k];
        end
      end
    end
  end

  // Output boundary: final stage registers drive the stream directly
  assign stream.y_valid = vld_p[STAGES-1];
  assign stream.y_ch    = ch_p[STAGES-1];
  assign stream.y       = d_p[STAGES-1];

endmodule

// File: tb/tb_cic_integrator_cascade.sv
// Directed bench for cic_integrator_cascade: three configurations (1/4/2 stages) share clk and rst.
module tb_cic_integrator_cascade;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cic_integrator_cascade_if #(.IN_WIDTH(12), .ACC_WIDTH(16), .CH_WIDTH(4)) if1 ();
  cic_integrator_cascade_if #(.IN_WIDTH(12), .ACC_WIDTH(32), .CH_WIDTH(4)) if4 ();
  cic_integrator_cascade_if #(.IN_WIDTH(12), .ACC_WIDTH(32), .CH_WIDTH(4)) if2 ();

`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
  logic       clr2    = 1'b0;
  logic [3:0] clr_ch2 = 4'd0;
`endif

  cic_integrator_cascade #(.IN_WIDTH(12), .ACC_WIDTH(16), .STAGES(1), .CHANNELS(1), .CH_WIDTH(4)) u1 (
    .clk(clk), .rst(rst),
`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
    .clr(1'b0), .clr_ch(4'd0),
`endif
    .stream(if1));

  cic_integrator_cascade #(.IN_WIDTH(12), .ACC_WIDTH(32), .STAGES(4), .CHANNELS(2), .CH_WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
    .clr(1'b0), .clr_ch(4'd0),
`endif
    .stream(if4));

  cic_integrator_cascade #(.IN_WIDTH(12), .ACC_WIDTH(32), .STAGES(2), .CHANNELS(2), .CH_WIDTH(4)) u2 (
    .clk(clk), .rst(rst),
`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
    .clr(clr2), .clr_ch(clr_ch2),
`endif
    .stream(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if1.x_valid = 1'b0; if4.x_valid = 1'b0; if2.x_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    if1.x_ch = '0; if1.x = '0;
    if4.x_ch = '0; if4.x = '0;
    if2.x_ch = '0; if2.x = '0;
    do_reset();
    n_tests++;
    if (if1.y_valid !== 1'b0 || if1.y_ch !== 4'd0 || if1.y !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_u1: got v=%0b ch=%0d y=%0d, expected 0 0 0", if1.y_valid, if1.y_ch, if1.y);
    end
    n_tests++;
    if (if4.y_valid !== 1'b0 || if4.y_ch !== 4'd0 || if4.y !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_u4: got v=%0b ch=%0d y=%0d, expected 0 0 0", if4.y_valid, if4.y_ch, if4.y);
    end
    n_tests++;
    if (if2.y_valid !== 1'b0 || if2.y_ch !== 4'd0 || if2.y !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_u2: got v=%0b ch=%0d y=%0d, expected 0 0 0", if2.y_valid, if2.y_ch, if2.y);
    end
  endtask

  // One integrator: a unit impulse followed by zeros holds at 1.
  task automatic test_impulse();
    do_reset();
    if1.x_ch = '0; if1.x = 12'sd1; if1.x_valid = 1'b1;
    tick();
    for (int n = 1; n <= 6; n++) begin
      n_tests++;
      if (if1.y_valid !== 1'b1 || if1.y !== 16'sd1) begin
        n_fail++;
        $display("FAIL impulse n=%0d: got v=%0b y=%0d, expected v=1 y=1", n, if1.y_valid, if1.y);
      end
      if1.x = 12'sd0;
      tick();
    end
    if1.x_valid = 1'b0;
  endtask

  // 16-bit accumulator fed -2048: reaches -32768 at sample 16, wraps to +30720 at 17.
  task automatic test_wrap();
    logic signed [15:0] e;
    do_reset();
    if1.x_ch = '0; if1.x = 12'h800; if1.x_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      e = 16'(-2048 * i);
      if (i == 17) e = 16'sh7800;
      n_tests++;
      if (if1.y_valid !== 1'b1 || if1.y !== e) begin
        n_fail++;
        $display("FAIL wrap i=%0d: got v=%0b y=%0d, expected v=1 y=%0d", i, if1.y_valid, if1.y, e);
      end
    end
    if1.x_valid = 1'b0;
  endtask

  // Four integrators on a unit step: sample j gives C(j+3,4); at edge n, j = n-3.
  task automatic test_step();
    int e;
    do_reset();
    if4.x_ch = 4'd0; if4.x = 12'sd1; if4.x_valid = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      n_tests++;
      if (n < 4) begin
        if (if4.y_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL step_latency n=%0d: got v=%0b, expected v=0", n, if4.y_valid);
        end
      end else begin
        e = n * (n - 1) * (n - 2) * (n - 3) / 24;
        if (if4.y_valid !== 1'b1 || if4.y !== 32'(e)) begin
          n_fail++;
          $display("FAIL step n=%0d: got v=%0b y=%0d, expected v=1 y=%0d", n, if4.y_valid, if4.y, e);
        end
      end
    end
    if4.x_valid = 1'b0;
  endtask

  // Four integrators on a unit impulse: 1,4,10,20,35,...
  task automatic test_impulse4();
    int e;
    do_reset();
    if4.x_ch = 4'd0; if4.x = 12'sd1; if4.x_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if4.x = 12'sd0;
      if (n >= 4) begin
        e = (n - 1) * (n - 2) * (n - 3) / 6;
        n_tests++;
        if (if4.y_valid !== 1'b1 || if4.y !== 32'(e)) begin
          n_fail++;
          $display("FAIL impulse4 n=%0d: got v=%0b y=%0d, expected v=1 y=%0d", n, if4.y_valid, if4.y, e);
        end
      end
    end
    if4.x_valid = 1'b0;
  endtask

  task automatic test_bad_channel();
    do_reset();
    if4.x = 12'sd7; if4.x_ch = 4'd2; if4.x_valid = 1'b1;
    tick();
    if4.x_ch = 4'd3;
    tick();
    if4.x_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      n_tests++;
      if (if4.y_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_channel_drop n=%0d: got v=%0b, expected v=0", n, if4.y_valid);
      end
      tick();
    end
    if4.x_ch = 4'd0; if4.x = 12'sd1; if4.x_valid = 1'b1;
    tick();
    if4.x_ch = 4'd1; if4.x = 12'sd2;
    tick();
    if4.x_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if (if4.y_valid !== 1'b1 || if4.y_ch !== 4'd0 || if4.y !== 32'sd1) begin
      n_fail++;
      $display("FAIL bad_channel_ch0: got v=%0b ch=%0d y=%0d, expected v=1 ch=0 y=1", if4.y_valid, if4.y_ch, if4.y);
    end
    tick();
    n_tests++;
    if (if4.y_valid !== 1'b1 || if4.y_ch !== 4'd1 || if4.y !== 32'sd2) begin
      n_fail++;
      $display("FAIL bad_channel_ch1: got v=%0b ch=%0d y=%0d, expected v=1 ch=1 y=2", if4.y_valid, if4.y_ch, if4.y);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    if4.x_ch = 4'd0; if4.x = 12'sd1; if4.x_valid = 1'b1;
    tick(); tick(); tick();
    if4.x_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      n_tests++;
      if (if4.y_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_flush n=%0d: got v=%0b, expected v=0", n, if4.y_valid);
      end
      tick();
    end
    if4.x_ch = 4'd1; if4.x = 12'sd5; if4.x_valid = 1'b1;
    tick();
    if4.x_ch = 4'd0; if4.x = 12'sd2;
    tick();
    if4.x_valid = 1'b0;
    tick();
    n_tests++;
    if (if4.y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_latency: got v=%0b, expected v=0", if4.y_valid);
    end
    tick();
    n_tests++;
    if (if4.y_valid !== 1'b1 || if4.y_ch !== 4'd1 || if4.y !== 32'sd5) begin
      n_fail++;
      $display("FAIL midreset_fresh: got v=%0b ch=%0d y=%0d, expected v=1 ch=1 y=5", if4.y_valid, if4.y_ch, if4.y);
    end
    tick();
    n_tests++;
    if (if4.y_valid !== 1'b1 || if4.y_ch !== 4'd0 || if4.y !== 32'sd2) begin
      n_fail++;
      $display("FAIL midreset_ch0: got v=%0b ch=%0d y=%0d, expected v=1 ch=0 y=2", if4.y_valid, if4.y_ch, if4.y);
    end
  endtask

  // Two integrators, ch0 x=1 and ch1 x=3 interleaved: j-th output is scale*j*(j+1)/2.
  task automatic test_multichannel();
    int m, c, j, e;
    do_reset();
    if2.x_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if2.x_ch = 4'((n - 1) % 2);
      if2.x = ((n - 1) % 2 == 1) ? 12'sd3 : 12'sd1;
      tick();
      if (n >= 2) begin
        m = n - 1;
        c = (m - 1) % 2;
        j = (m + 1) / 2;
        e = ((c == 1) ? 3 : 1) * j * (j + 1) / 2;
        n_tests++;
        if (if2.y_valid !== 1'b1 || if2.y_ch !== 4'(c) || if2.y !== 32'(e)) begin
          n_fail++;
          $display("FAIL multichannel n=%0d: got v=%0b ch=%0d y=%0d, expected v=1 ch=%0d y=%0d",
                   n, if2.y_valid, if2.y_ch, if2.y, c, e);
        end
      end
    end
    if2.x_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int in_v  [6] = '{1, 1, 0, 1, 0, 0};
    int exp_v [6] = '{0, 1, 1, 0, 1, 0};
    int exp_y [6] = '{0, 1, 3, 3, 6, 6};
    do_reset();
    if2.x_ch = 4'd0; if2.x = 12'sd1;
    for (int i = 0; i < 6; i++) begin
      if2.x_valid = (in_v[i] != 0);
      tick();
      n_tests++;
      if (if2.y_valid !== 1'(exp_v[i]) || if2.y !== 32'(exp_y[i])) begin
        n_fail++;
        $display("FAIL back_to_back i=%0d: got v=%0b y=%0d, expected v=%0d y=%0d",
                 i, if2.y_valid, if2.y, exp_v[i], exp_y[i]);
      end
    end
    if2.x_valid = 1'b0;
  endtask

`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
  task automatic test_clear();
    do_reset();
    if2.x = 12'sd1; if2.x_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if2.x_ch = 4'(n % 2);
      tick();
    end
    if2.x_valid = 1'b0;
    tick(); tick();
    clr2 = 1'b1; clr_ch2 = 4'd1;
    tick();
    clr2 = 1'b0;
    if2.x_ch = 4'd0; if2.x_valid = 1'b1;
    tick();
    if2.x_ch = 4'd1;
    tick();
    if2.x_valid = 1'b0;
    n_tests++;
    if (if2.y_valid !== 1'b1 || if2.y_ch !== 4'd0 || if2.y !== 32'sd6) begin
      n_fail++;
      $display("FAIL clear_ch0_kept: got v=%0b ch=%0d y=%0d, expected v=1 ch=0 y=6", if2.y_valid, if2.y_ch, if2.y);
    end
    tick();
    n_tests++;
    if (if2.y_valid !== 1'b1 || if2.y_ch !== 4'd1 || if2.y !== 32'sd1) begin
      n_fail++;
      $display("FAIL clear_ch1_zeroed: got v=%0b ch=%0d y=%0d, expected v=1 ch=1 y=1", if2.y_valid, if2.y_ch, if2.y);
    end
  endtask
`endif

  initial begin
    if1.x_valid = 1'b0; if4.x_valid = 1'b0; if2.x_valid = 1'b0;
    test_reset();
    test_impulse();
    test_wrap();
    test_step();
    test_impulse4();
    test_bad_channel();
    test_reset_midstream();
    test_multichannel();
    test_back_to_back();
`ifdef CIC_INTEGRATOR_CASCADE_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
